// File: rtl/tfpga_rst_seq_pkg.sv
// tfpga_rst_seq_pkg: sequencer state encoding and default timing constants
package tfpga_rst_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        RELEASE,
        RUN,
        FAIL
    } seq_state_t;

    localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 65536;
    localparam int DEF_PLL_RST_CYCLES      = 16;
    localparam int DEF_STAGE_GAP_CYCLES    = 64;
    localparam int DEF_NUM_STAGES          = 3;
    localparam int DEF_MAX_RETRIES         = 4;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tfpga_sync2.sv
// tfpga_sync2: two-flop synchronizer, asynchronously cleared to 0
module tfpga_sync2 (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/tfpga_clk_rst_seq.sv
// tfpga_clk_rst_seq: PLL reset/retry, lock qualification and ordered domain reset release
module tfpga_clk_rst_seq
    import tfpga_rst_seq_pkg::*;
#(
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
    parameter int STAGE_GAP_CYCLES    = DEF_STAGE_GAP_CYCLES,
    parameter int NUM_STAGES          = DEF_NUM_STAGES,
    parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  pll_locked,
    input  logic                  sw_reseq,
    input  logic                  sw_clear_fail,
    output logic                  pll_reset,
    output logic [NUM_STAGES-1:0] domain_rst_n,
    output logic                  ready,
    output logic                  fail,
    output logic [7:0]            lock_loss_cnt
);

    // One counter serves every timed phase, so it is sized for the longest one.
    localparam int CNT_MAX = max2(max2(LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES),
                                  max2(PLL_RST_CYCLES, STAGE_GAP_CYCLES));
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam int RW = $clog2(MAX_RETRIES + 1);
    localparam logic [CW-1:0]         RST_LAST  = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0]         TMO_LAST  = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0]         STB_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0]         GAP_LAST  = CW'(STAGE_GAP_CYCLES - 1);
    localparam logic [RW-1:0]         RETRY_MAX = RW'(MAX_RETRIES);
    localparam logic [NUM_STAGES-1:0] DOM_FIRST = NUM_STAGES'(1);

    seq_state_t            r_state, w_state_nx;
    logic [CW-1:0]         r_cnt, w_cnt_nx;
    logic [RW-1:0]         r_retry, w_retry_nx;
    logic [NUM_STAGES-1:0] r_dom, w_dom_nx, w_dom_shift;
    logic                  r_pll_reset, r_ready, r_fail;
    logic [7:0]            r_loss;
    logic                  w_lock_s, w_loss, w_reseq;

    tfpga_sync2 u_lock_sync (
        .i_clk   (sys_clk),
        .i_rst_n (sys_rst_n),
        .i_d     (pll_locked),
        .o_q     (w_lock_s)
    );

    assign w_loss      = !w_lock_s && (r_state inside {RELEASE, RUN});
    assign w_reseq     = sw_reseq && !(r_state inside {PLL_RST, FAIL});
    assign w_dom_shift = (r_dom << 1) | DOM_FIRST;

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt + 1'b1;
        w_retry_nx = r_retry;
        w_dom_nx   = r_dom;
        case (r_state)
            PLL_RST: begin
                if (r_cnt == RST_LAST) begin
                    w_state_nx = WAIT_LOCK;
                    w_cnt_nx   = '0;
                end
            end
            WAIT_LOCK: begin
                if (w_lock_s) begin
                    w_state_nx = STABLE;
                    w_cnt_nx   = '0;
                end else if (r_cnt == TMO_LAST) begin
                    w_retry_nx = r_retry + 1'b1;
                    w_state_nx = (w_retry_nx == RETRY_MAX) ? FAIL : PLL_RST;
                    w_cnt_nx   = '0;
                end
            end
            STABLE: begin
                if (!w_lock_s) begin
                    w_state_nx = WAIT_LOCK;
                    w_cnt_nx   = '0;
                end else if (r_cnt == STB_LAST) begin
                    w_retry_nx = '0;
                    w_dom_nx   = DOM_FIRST;
                    w_state_nx = (NUM_STAGES == 1) ? RUN : RELEASE;
                    w_cnt_nx   = '0;
                end
            end
            RELEASE: begin
                if (r_cnt == GAP_LAST) begin
                    w_dom_nx   = w_dom_shift;
                    w_state_nx = (&w_dom_shift) ? RUN : RELEASE;
                    w_cnt_nx   = '0;
                end
            end
            RUN: w_cnt_nx = '0;
            FAIL: begin
                w_cnt_nx = '0;
                if (sw_clear_fail) begin
                    w_state_nx = PLL_RST;
                    w_retry_nx = '0;
                end
            end
            default: w_state_nx = PLL_RST;
        endcase
        // Lock loss and software re-sequence share one path back to PLL reset.
        if (w_loss || w_reseq) begin
            w_state_nx = PLL_RST;
            w_cnt_nx   = '0;
            w_dom_nx   = '0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= PLL_RST;
            r_cnt       <= '0;
            r_retry     <= '0;
            r_dom       <= '0;
            r_pll_reset <= 1'b1;
            r_ready     <= 1'b0;
            r_fail      <= 1'b0;
            r_loss      <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_retry     <= w_retry_nx;
            r_dom       <= w_dom_nx;
            r_pll_reset <= (w_state_nx == PLL_RST) || (w_state_nx == FAIL);
            r_ready     <= w_state_nx == RUN;
            r_fail      <= w_state_nx == FAIL;
            r_loss      <= (w_loss && r_loss != 8'hFF) ? r_loss + 1'b1 : r_loss;
        end
    end

    assign pll_reset     = r_pll_reset;
    assign domain_rst_n  = r_dom;
    assign ready         = r_ready;
    assign fail          = r_fail;
    assign lock_loss_cnt = r_loss;

endmodule

// File: tb/tb_tfpga_clk_rst_seq.sv
// tb_tfpga_clk_rst_seq: directed bench; expected output changes are queued with their
// cycle numbers and a monitor compares every observed output change against the queue.
module tb_tfpga_clk_rst_seq;

    typedef struct {
        int          cyc;
        logic [13:0] v;
        string       tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n, pll_locked, sw_reseq, sw_clear_fail;
    logic       pll_reset, ready, fail;
    logic [2:0] domain_rst_n;
    logic [7:0] lock_loss_cnt;

    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    int          exp_loss = 0;
    logic        done = 1'b0;
    logic        first = 1'b1;
    logic [13:0] prev, cur;
    exp_t        q[$];
    exp_t        e;

    tfpga_clk_rst_seq #(
        .LOCK_STABLE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (32),
        .PLL_RST_CYCLES      (4),
        .STAGE_GAP_CYCLES    (4),
        .NUM_STAGES          (3),
        .MAX_RETRIES         (2)
    ) dut (
        .sys_clk       (clk),
        .sys_rst_n     (rst_n),
        .pll_locked    (pll_locked),
        .sw_reseq      (sw_reseq),
        .sw_clear_fail (sw_clear_fail),
        .pll_reset     (pll_reset),
        .domain_rst_n  (domain_rst_n),
        .ready         (ready),
        .fail          (fail),
        .lock_loss_cnt (lock_loss_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [13:0] pk(input logic pr, input logic [2:0] d, input logic rd,
                                       input logic fl, input int ls);
        return {pr, d, rd, fl, 8'(ls)};
    endfunction

    task automatic exp_at(input int rel, input logic [13:0] v, input string tag);
        exp_t x;
        x.cyc = cyc + rel;
        x.v   = v;
        x.tag = tag;
        q.push_back(x);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Lock rising now: bit 0 after sync(2)+stable(9), then 4-cycle stage gaps.
    task automatic lock_on(input string tag);
        pll_locked = 1'b1;
        exp_at(11, pk(1'b0, 3'b001, 1'b0, 1'b0, exp_loss), {tag, "_dom001"});
        exp_at(15, pk(1'b0, 3'b011, 1'b0, 1'b0, exp_loss), {tag, "_dom011"});
        exp_at(19, pk(1'b0, 3'b111, 1'b1, 1'b0, exp_loss), {tag, "_dom111"});
    endtask

    always @(negedge clk) begin
        cur = {pll_reset, domain_rst_n, ready, fail, lock_loss_cnt};
        if (first || cur !== prev) begin
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_change cyc=%0d got=%h want=no change", cyc, cur);
            end else begin
                e = q.pop_front();
                if (e.cyc != cyc || e.v !== cur) begin
                    miscompares++;
                    $display("FAIL %s got=%h at cyc %0d want=%h at cyc %0d", e.tag, cur, cyc, e.v, e.cyc);
                end
            end
            prev  = cur;
            first = 1'b0;
        end else if (q.size() != 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL %s got=no change (outputs %h) want=%h at cyc %0d", e.tag, cur, e.v, e.cyc);
        end
        if (done) begin
            vectors++;
            if (q.size() != 0) begin
                miscompares++;
                $display("FAIL pending_events got=%0d left want=0", q.size());
            end
            $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
            $finish;
        end
    end

    initial begin
        rst_n = 1'b1; pll_locked = 1'b0; sw_reseq = 1'b0; sw_clear_fail = 1'b0;
        exp_at(1, pk(1'b1, 3'b000, 1'b0, 1'b0, 0), "reset_state");
        #1 rst_n = 1'b0;
        step(3);
        // Nominal bring-up: pll_reset drops on the 4th edge, lock 10 cycles after release
        rst_n = 1'b1;
        exp_at(4, pk(1'b0, 3'b000, 1'b0, 1'b0, 0), "pll_rst_end");
        step(10);
        lock_on("bringup");
        step(24);
        // Lock loss in RUN: domains, ready and pll_reset react 3 cycles after the pin
        pll_locked = 1'b0;
        exp_loss++;
        exp_at(3, pk(1'b1, 3'b000, 1'b0, 1'b0, exp_loss), "loss_assert");
        exp_at(7, pk(1'b0, 3'b000, 1'b0, 1'b0, exp_loss), "loss_pll_rst_end");
        step(10);
        // One-cycle glitch in STABLE: release delayed to 8 fresh stable cycles
        pll_locked = 1'b1;
        exp_at(17, pk(1'b0, 3'b001, 1'b0, 1'b0, exp_loss), "glitch_dom001");
        exp_at(21, pk(1'b0, 3'b011, 1'b0, 1'b0, exp_loss), "glitch_dom011");
        exp_at(25, pk(1'b0, 3'b111, 1'b1, 1'b0, exp_loss), "glitch_dom111");
        step(5);
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        step(24);
        // Lock loss and sw_reseq on the same edge: counted once
        pll_locked = 1'b0;
        step(2);
        sw_reseq = 1'b1;
        exp_loss++;
        exp_at(1, pk(1'b1, 3'b000, 1'b0, 1'b0, exp_loss), "both_assert");
        exp_at(5, pk(1'b0, 3'b000, 1'b0, 1'b0, exp_loss), "both_pll_rst_end");
        step(1);
        sw_reseq = 1'b0;
        step(5);
        // 300 losses during RELEASE: counter saturates at 255
        for (int i = 0; i < 300; i++) begin
            pll_locked = 1'b1;
            exp_at(11, pk(1'b0, 3'b001, 1'b0, 1'b0, exp_loss), "sat_dom001");
            step(11);
            pll_locked = 1'b0;
            exp_loss = (exp_loss == 255) ? 255 : exp_loss + 1;
            exp_at(3, pk(1'b1, 3'b000, 1'b0, 1'b0, exp_loss), "sat_loss");
            exp_at(7, pk(1'b0, 3'b000, 1'b0, 1'b0, exp_loss), "sat_pll_rst_end");
            step(8);
        end
        // Timeouts: retry pulse 32 cycles into WAIT_LOCK, FAIL after the second
        exp_at(31, pk(1'b1, 3'b000, 1'b0, 1'b0, exp_loss), "timeout1_pll_rst");
        exp_at(35, pk(1'b0, 3'b000, 1'b0, 1'b0, exp_loss), "timeout1_pll_rst_end");
        exp_at(67, pk(1'b1, 3'b000, 1'b0, 1'b1, exp_loss), "timeout2_fail");
        step(70);
        sw_reseq = 1'b1;
        step(1);
        sw_reseq = 1'b0;
        step(3);
        // Clear FAIL, then a reseq inside PLL_RST must not stretch the pulse
        sw_clear_fail = 1'b1;
        exp_at(1, pk(1'b1, 3'b000, 1'b0, 1'b0, exp_loss), "clear_fail");
        exp_at(5, pk(1'b0, 3'b000, 1'b0, 1'b0, exp_loss), "clear_pll_rst_end");
        step(1);
        sw_clear_fail = 1'b0;
        step(1);
        sw_reseq = 1'b1;
        step(1);
        sw_reseq = 1'b0;
        step(3);
        // Async reset with domains at 011: change seen before the next clock edge
        pll_locked = 1'b1;
        exp_at(11, pk(1'b0, 3'b001, 1'b0, 1'b0, exp_loss), "async_dom001");
        exp_at(15, pk(1'b0, 3'b011, 1'b0, 1'b0, exp_loss), "async_dom011");
        step(16);
        rst_n = 1'b0;
        exp_loss = 0;
        exp_at(0, pk(1'b1, 3'b000, 1'b0, 1'b0, 0), "async_reset");
        step(3);
        rst_n = 1'b1;
        exp_at(4,  pk(1'b0, 3'b000, 1'b0, 1'b0, 0), "rerst_pll_rst_end");
        exp_at(13, pk(1'b0, 3'b001, 1'b0, 1'b0, 0), "rerst_dom001");
        exp_at(17, pk(1'b0, 3'b011, 1'b0, 1'b0, 0), "rerst_dom011");
        exp_at(21, pk(1'b0, 3'b111, 1'b1, 1'b0, 0), "rerst_dom111");
        step(25);
        done = 1'b1;
        step(2);
    end

endmodule
